// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 bit-plane (BCM) panel driver.
package hub75_pkg;

    typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;

    // Bit positions of each panel colour line within rgb = {R1,G1,B1,R2,G2,B2}.
    localparam int RGB_R1 = 5;
    localparam int RGB_G1 = 4;
    localparam int RGB_B1 = 3;
    localparam int RGB_R2 = 2;
    localparam int RGB_G2 = 1;
    localparam int RGB_B2 = 0;

    localparam int CNT_W = 16;

    // Binary-weighted on-time for one bit plane; plane 0 is the least significant.
    function automatic logic [CNT_W-1:0] plane_len(input int base_on, input int plane);
        return CNT_W'(base_on << plane);
    endfunction

endpackage

// File: rtl/hub75_fb_dpram.sv
// Double-buffered frame store: two banks selected per port, one write port and
// one registered read port (1-cycle read latency). Contents are never reset.
module hub75_fb_dpram #(
    parameter int AW = 4,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel driver with binary code modulation and a double-buffered frame store.
// FSM counters run one cycle ahead of the registered panel outputs.
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 3,
    parameter int DEPTH    = 2,
    parameter int BASE_ON  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [ROW_BITS+$clog2(COLS)-1:0]  wr_addr,
    input  logic [6*DEPTH-1:0]                wr_data,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              frame_start,
    output logic [5:0]                        rgb,
    output logic                              outclk,
    output logic                              lat,
    output logic                              oe_n,
    output logic [ROW_BITS-1:0]               abc
);

    localparam int COL_BITS = $clog2(COLS);
    localparam int AW       = ROW_BITS + COL_BITS;
    localparam int PLANE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              st, st_n;
    logic                ph, ph_n;
    logic [COL_BITS-1:0] col, col_n;
    logic [PLANE_W-1:0]  plane, plane_n;
    logic [ROW_BITS-1:0] row, row_n;
    logic [CNT_W-1:0]    cnt, cnt_n, plane_last;
    logic                front, swap_now, frame_end, take, rd_bank;
    logic [6*DEPTH-1:0]  rd_data, plane_word;
    logic [5:0]          plane_bits, rgb_d;
    logic                outclk_d, lat_d, oe_n_d, frame_start_d;
    logic [ROW_BITS-1:0] abc_d;

    assign plane_last = plane_len(BASE_ON, int'(plane)) - 1'b1;
    assign frame_end  = (st == DISPLAY) && (cnt == plane_last) &&
                        (plane == PLANE_W'(DEPTH-1)) && (row == '1);
    assign take       = frame_end && swap_req;
    // Frame 0 of the new image is fetched before front flips, so the read bank looks ahead.
    assign rd_bank    = front ^ (take | swap_now);

    hub75_fb_dpram #(.AW(AW), .DW(6*DEPTH)) u_fb (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (~front),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_bank (rd_bank),
        .rd_addr ({row_n, col_n}),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= SHIFT;
            ph       <= 1'b0;
            col      <= '0;
            plane    <= '0;
            row      <= '0;
            cnt      <= '0;
            front    <= 1'b0;
            swap_now <= 1'b0;
        end else begin
            st       <= st_n;
            ph       <= ph_n;
            col      <= col_n;
            plane    <= plane_n;
            row      <= row_n;
            cnt      <= cnt_n;
            front    <= front ^ swap_now;
            swap_now <= take;
        end
    end

    always_comb begin
        st_n    = st;
        ph_n    = ph;
        col_n   = col;
        plane_n = plane;
        row_n   = row;
        cnt_n   = cnt;
        case (st)
            SHIFT: begin
                ph_n = ~ph;
                if (ph) begin
                    if (col == COL_BITS'(COLS-1)) begin
                        col_n = '0;
                        st_n  = BLANK;
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            end
            BLANK: st_n = LATCH;
            LATCH: begin
                st_n  = DISPLAY;
                cnt_n = '0;
            end
            DISPLAY: begin
                if (cnt == plane_last) begin
                    st_n  = SHIFT;
                    cnt_n = '0;
                    if (plane == PLANE_W'(DEPTH-1)) begin
                        plane_n = '0;
                        row_n   = row + 1'b1;
                    end else begin
                        plane_n = plane + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: st_n = SHIFT;
        endcase
    end

    assign plane_word = rd_data >> plane;
    for (genvar j = RGB_B2; j <= RGB_R1; j++) begin : g_plane_bit
        assign plane_bits[j] = plane_word[j*DEPTH];
    end

    always_comb begin
        rgb_d         = '0;
        outclk_d      = 1'b0;
        lat_d         = 1'b0;
        oe_n_d        = 1'b1;
        abc_d         = abc;
        frame_start_d = (st == SHIFT) && !ph && (col == '0) && (plane == '0) && (row == '0);
        case (st)
            SHIFT: begin
                if (ph) begin
                    rgb_d    = rgb;
                    outclk_d = 1'b1;
                end else begin
                    rgb_d = plane_bits;
                end
            end
            BLANK:   abc_d  = row;
            LATCH:   lat_d  = 1'b1;
            DISPLAY: oe_n_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb         <= '0;
            outclk      <= 1'b0;
            lat         <= 1'b0;
            oe_n        <= 1'b1;
            abc         <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb         <= rgb_d;
            outclk      <= outclk_d;
            lat         <= lat_d;
            oe_n        <= oe_n_d;
            abc         <= abc_d;
            swap_ack    <= swap_now;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver at COLS=4, ROW_BITS=1, DEPTH=2, BASE_ON=2.
module tb_hub75_bcm_driver;

    localparam int COLS     = 4;
    localparam int ROW_BITS = 1;
    localparam int DEPTH    = 2;
    localparam int BASE_ON  = 2;
    localparam int ROW_LEN  = 26;   // (8+2+2) + (8+2+4)
    localparam int FRAME    = 52;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack, frame_start, outclk, lat, oe_n;
    logic [5:0]  rgb;
    logic [0:0]  abc;

    int vectors = 0;
    int errors  = 0;
    bit front   = 1'b0;
    logic [11:0] img [0:1][0:1][0:3];

    hub75_bcm_driver #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_ON(BASE_ON)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .rgb         (rgb),
        .outclk      (outclk),
        .lat         (lat),
        .oe_n        (oe_n),
        .abc         (abc)
    );

    always #5 clk = ~clk;

    // Expected {frame_start, rgb, outclk, lat, oe_n, abc} at cycle t of a frame.
    function automatic logic [10:0] model(input int t, input bit first, input bit bank);
        int r, u, p, v;
        logic [11:0] w;
        logic [5:0]  e_rgb;
        logic        e_clk, e_lat, e_oe;
        logic [0:0]  e_abc;
        r = t / ROW_LEN;
        u = t % ROW_LEN;
        p = (u < 12) ? 0 : 1;
        v = (p == 0) ? u : u - 12;
        e_rgb = '0;
        e_clk = 1'b0;
        e_lat = 1'b0;
        e_oe  = 1'b1;
        if (u < 8) e_abc = (first && r == 0) ? 1'b0 : 1'(1 - r);
        else       e_abc = 1'(r);
        if (v < 8) begin
            e_clk = v[0];
            w = img[bank][r][v/2];
            for (int j = 0; j < 6; j++) e_rgb[j] = w[j*DEPTH + p];
        end else if (v == 9) begin
            e_lat = 1'b1;
        end else if (v >= 10) begin
            e_oe = 1'b0;
        end
        return {(t == 0), e_rgb, e_clk, e_lat, e_oe, e_abc};
    endfunction

    task automatic check_frame(input string tag, input bit first, input bit use_rgb, input int raise_at);
        logic [10:0] exp_v, got_v, mask;
        mask = use_rgb ? 11'h7FF : 11'h40F;
        for (int t = 0; t < FRAME; t++) begin
            exp_v = model(t, first, front) & mask;
            got_v = {frame_start, rgb, outclk, lat, oe_n, abc} & mask;
            vectors++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got_v, exp_v);
            end
            if (t == 1) begin
                vectors++;
                if (swap_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL %s swap_ack_width got=%b exp=0", tag, swap_ack);
                end
            end
            if (t == raise_at) swap_req = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic write_word(input logic [2:0] a, input logic [11:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        img[~front][a[2]][a[1:0]] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_frame_start(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 2*FRAME) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_start timeout got=%b exp=1", tag, frame_start);
        end
    endtask

    task automatic do_swap(input string tag);
        int n = 0;
        logic prev_oe;
        swap_req = 1'b1;
        prev_oe  = oe_n;
        while (swap_ack !== 1'b1 && n < 3*FRAME) begin
            prev_oe = oe_n;
            @(negedge clk);
            n++;
        end
        swap_req = 1'b0;
        vectors++;
        if ({swap_ack, frame_start, prev_oe} !== 3'b110) begin
            errors++;
            $display("FAIL %s ack/frame_start/prev_oe_n got=%b exp=110", tag,
                     {swap_ack, frame_start, prev_oe});
        end
        front = ~front;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({frame_start, rgb, outclk, lat, oe_n, abc, swap_ack} !== 12'h004) begin
            errors++;
            $display("FAIL reset_state got=%h exp=004",
                     {frame_start, rgb, outclk, lat, oe_n, abc, swap_ack});
        end
    endtask

    task automatic test_frame_timing();
        reset = 1'b0;
        @(negedge clk);
        check_frame("boot", 1'b1, 1'b0, -1);
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_len frame_start@52 got=%b exp=1", frame_start);
        end
    endtask

    task automatic test_image();
        for (int a = 0; a < 8; a++) write_word(3'(a), 12'h000);
        do_swap("swap_fill");
        for (int a = 0; a < 8; a++) write_word(3'(a), (a == 2) ? 12'hC30 : 12'h000);
        do_swap("swap_a");
        check_frame("img_a", 1'b0, 1'b1, -1);
    endtask

    task automatic test_midframe_swap();
        write_word(3'd5, 12'h30F);
        write_word(3'd3, 12'hFFF);
        wait_frame_start("mid_sync");
        check_frame("hold_a", 1'b0, 1'b1, 20);
        vectors++;
        if ({swap_ack, frame_start} !== 2'b11) begin
            errors++;
            $display("FAIL mid_swap ack/frame_start got=%b exp=11", {swap_ack, frame_start});
        end
        swap_req = 1'b0;
        front = ~front;
        check_frame("show_b", 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_midframe();
        repeat (36) @(negedge clk);
        vectors++;
        if ({oe_n, abc} !== 2'b01) begin
            errors++;
            $display("FAIL pre_reset oe_n/abc got=%b exp=01", {oe_n, abc});
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({frame_start, rgb, outclk, lat, oe_n, abc, swap_ack} !== 12'h004) begin
            errors++;
            $display("FAIL async_reset got=%h exp=004",
                     {frame_start, rgb, outclk, lat, oe_n, abc, swap_ack});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        front = 1'b0;
        @(negedge clk);
        check_frame("rst_a", 1'b1, 1'b1, -1);
        do_swap("swap_b2");
        check_frame("img_b2", 1'b0, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_image();
        test_midframe_swap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
